// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, access-size codes and the legality check.
// The RMW states exist only when DMEM_ARB_RMW_EN is defined.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISS,
    RD_CAP,
    WR_ISS,
`ifdef DMEM_ARB_RMW_EN
    RMW_RD,
    RMW_CAP,
    RMW_WR,
`endif
    RESP
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  // Natural alignment is required; illegal size code is always rejected.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b1;
    if (size == SZ_ILL) ok = 1'b0;
    else if (size == SZ_HALF && addr_lo[0]) ok = 1'b0;
    else if (size == SZ_WORD && addr_lo != 2'b00) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/acknowledge bundle of the data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              REQ;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [1:0]        SIZE;
  logic [DATA_W-1:0] WD;
  logic              ACK;
  logic [DATA_W-1:0] RD;
  logic              ERR;

  modport master (output REQ, WE, ADDR, SIZE, WD, input ACK, RD, ERR);
  modport slave  (input REQ, WE, ADDR, SIZE, WD, output ACK, RD, ERR);
endinterface

// File: rtl/dmem_lane_mux.sv
// Little-endian lane logic: extracts and zero-extends a sub-word (merge = 0)
// or merges the low bits of wd into the addressed lane of word (merge = 1).
module dmem_lane_mux
  import dmem_arb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wd,
  input  logic        merge,
  output logic [31:0] word_out
);

  always_comb begin
    word_out = word;
    if (merge) begin
      case (size)
        SZ_HALF: word_out[{addr_lo[1], 4'b0000} +: 16] = wd[15:0];
        SZ_BYTE: word_out[{addr_lo, 3'b000} +: 8]      = wd[7:0];
        default: word_out = wd;
      endcase
    end else begin
      case (size)
        SZ_HALF: word_out = {16'b0, word[{addr_lo[1], 4'b0000} +: 16]};
        SZ_BYTE: word_out = {24'b0, word[{addr_lo, 3'b000} +: 8]};
        default: word_out = word;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin controller in front of the data memory.
// Define DMEM_ARB_RMW_EN to turn sub-word writes into word read-modify-write sequences.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  dmem_arbiter_if.slave     M0,
  dmem_arbiter_if.slave     M1,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_RA,
  output logic [ADDR_W-1:0] MEM_WA,
  output logic [DATA_W-1:0] MEM_WD,
  output logic [1:0]        MEM_SIZE,
  input  logic [DATA_W-1:0] MEM_RD
);

  state_t state_q, state_d;
  logic   last_q, gnt_q, err_q;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wd_q, rdata_q;

  logic              gnt_vld, gnt_sel, sel_we, sel_legal, do_grant, lane_merge;
  logic [ADDR_W-1:0] sel_addr, word_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wd, lane_word, rsp_rd;

  // On a tie the requester that was not served last wins.
  assign gnt_vld   = M0.REQ | M1.REQ;
  assign gnt_sel   = (M0.REQ & M1.REQ) ? ~last_q : M1.REQ;
  assign sel_we    = gnt_sel ? M1.WE   : M0.WE;
  assign sel_addr  = gnt_sel ? M1.ADDR : M0.ADDR;
  assign sel_size  = gnt_sel ? M1.SIZE : M0.SIZE;
  assign sel_wd    = gnt_sel ? M1.WD   : M0.WD;
  assign sel_legal = is_legal(sel_size, sel_addr[1:0]);
  assign do_grant  = (state_q == IDLE) && gnt_vld;
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef DMEM_ARB_RMW_EN
  assign lane_merge = (state_q == RMW_CAP);
`else
  assign lane_merge = 1'b0;
`endif

  dmem_lane_mux u_lane (
    .word     (MEM_RD),
    .addr_lo  (addr_q[1:0]),
    .size     (size_q),
    .wd       (wd_q),
    .merge    (lane_merge),
    .word_out (lane_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_grant) begin
        last_q <= gnt_sel;
        gnt_q  <= gnt_sel;
        err_q  <= ~sel_legal;
      end
    end
  end

  // Request fields and captured data carry no reset; every output use is gated by state.
  always_ff @(posedge CLK) begin
    if (do_grant) begin
      we_q   <= sel_we;
      addr_q <= sel_addr;
      size_q <= sel_size;
      wd_q   <= sel_wd;
    end
    if (state_q == RD_CAP
`ifdef DMEM_ARB_RMW_EN
        || state_q == RMW_CAP
`endif
       ) rdata_q <= lane_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          if (!sel_legal)                state_d = RESP;
          else if (!sel_we)              state_d = RD_ISS;
`ifdef DMEM_ARB_RMW_EN
          else if (sel_size != SZ_WORD)  state_d = RMW_RD;
`endif
          else                           state_d = WR_ISS;
        end
      end
      RD_ISS:  state_d = RD_CAP;
      RD_CAP:  state_d = RESP;
      WR_ISS:  state_d = RESP;
`ifdef DMEM_ARB_RMW_EN
      RMW_RD:  state_d = RMW_CAP;
      RMW_CAP: state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    MEM_RE   = 1'b0;
    MEM_WE   = 1'b0;
    MEM_RA   = '0;
    MEM_WA   = '0;
    MEM_WD   = '0;
    MEM_SIZE = SZ_WORD;
    case (state_q)
      RD_ISS: begin
        MEM_RE = 1'b1;
        MEM_RA = word_addr;
      end
      WR_ISS: begin
        MEM_WE   = 1'b1;
        MEM_WA   = addr_q;
        MEM_WD   = wd_q;
        MEM_SIZE = size_q;
      end
`ifdef DMEM_ARB_RMW_EN
      RMW_RD: begin
        MEM_RE = 1'b1;
        MEM_RA = word_addr;
      end
      RMW_WR: begin
        MEM_WE = 1'b1;
        MEM_WA = word_addr;
        MEM_WD = rdata_q;
      end
`endif
      default: ;
    endcase
  end

  assign rsp_rd = (err_q | we_q) ? '0 : rdata_q;

  assign M0.ACK = (state_q == RESP) & ~gnt_q;
  assign M1.ACK = (state_q == RESP) &  gnt_q;
  assign M0.RD  = M0.ACK ? rsp_rd : '0;
  assign M1.RD  = M1.ACK ? rsp_rd : '0;
  assign M0.ERR = M0.ACK & err_q;
  assign M1.ERR = M1.ACK & err_q;

endmodule
